// File: rtl/fifo_wr_arbiter_if.sv
// Bus between four write requesters and the shared FIFO write port.
// The arbiter uses the slave modport; whatever drives requests and the full flag uses master.
interface fifo_wr_arbiter_if #(
  parameter int DSIZE = 8
);
  logic [3:0]         req;
  logic [4*DSIZE-1:0] din;
  logic               wfull;
  logic [3:0]         gnt;
  logic [3:0]         ack;
  logic               winc;
  logic [DSIZE-1:0]   wdata;
  logic               abort;

  modport master (
    output req, din, wfull,
    input  gnt, ack, winc, wdata, abort
  );

  modport slave (
    input  req, din, wfull,
    output gnt, ack, winc, wdata, abort
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter giving four requesters bounded write bursts into one FIFO, with stall timeout.
// Define FIFO_WR_ARBITER_PRIO_EN to let requester 0 win every arbitration it takes part in.
module fifo_wr_arbiter #(
  parameter int DSIZE       = 8,
  parameter int BURST       = 4,
  parameter int STALL_LIMIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);

`ifdef FIFO_WR_ARBITER_PRIO_EN
  localparam bit PRIO_EN = 1'b1;
`else
  localparam bit PRIO_EN = 1'b0;
`endif

  localparam logic [3:0] BURST_MAX = 4'(BURST);
  localparam logic [7:0] STALL_MAX = 8'(STALL_LIMIT);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_next;
  logic [1:0] owner, owner_next;
  logic [1:0] last, last_next;
  logic [3:0] gnt_r, gnt_next;
  logic [3:0] burst_cnt, burst_next;
  logic [7:0] stall_cnt, stall_next;
  logic       abort_r, abort_next;

  logic       owner_req;
  logic       winc;
  logic       stalling;
  logic       burst_done;
  logic       stall_hit;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;

  assign owner_req  = bus.req[owner];
  assign winc       = (state == GRANT) & owner_req & ~bus.wfull;
  assign stalling   = (state == GRANT) & owner_req & bus.wfull;
  assign burst_done = winc && (burst_cnt == BURST_MAX - 4'd1);
  assign stall_hit  = stalling && (stall_cnt == STALL_MAX - 8'd1);

  assign bus.winc  = winc;
  assign bus.ack   = winc ? gnt_r : 4'b0000;
  assign bus.gnt   = gnt_r;
  assign bus.abort = abort_r;
  assign bus.wdata = (gnt_r != 4'b0000) ? bus.din[owner*DSIZE +: DSIZE] : '0;

  // Search starts just past the last owner so every requester gets a turn.
  always_comb begin
    pick  = last;
    idx   = last;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    if (PRIO_EN && bus.req[0]) pick = 2'd0;
  end

  always_comb begin
    state_next = state;
    owner_next = owner;
    last_next  = last;
    gnt_next   = gnt_r;
    burst_next = burst_cnt;
    stall_next = 8'd0;
    abort_next = 1'b0;
    case (state)
      IDLE: begin
        gnt_next   = 4'b0000;
        burst_next = 4'd0;
        if (|bus.req) begin
          state_next = GRANT;
          owner_next = pick;
          gnt_next   = 4'b0001 << pick;
        end
      end
      GRANT: begin
        if (winc) burst_next = burst_cnt + 4'd1;
        if (stalling) stall_next = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 8'd1;
        // A dropped request releases quietly; stall_hit implies the request is still up.
        if (!owner_req || burst_done || stall_hit) begin
          state_next = IDLE;
          gnt_next   = 4'b0000;
          last_next  = owner;
          abort_next = stall_hit;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      owner     <= 2'd0;
      last      <= 2'd3;
      gnt_r     <= 4'b0000;
      burst_cnt <= 4'd0;
      stall_cnt <= 8'd0;
      abort_r   <= 1'b0;
    end else begin
      state     <= state_next;
      owner     <= owner_next;
      last      <= last_next;
      gnt_r     <= gnt_next;
      burst_cnt <= burst_next;
      stall_cnt <= stall_next;
      abort_r   <= abort_next;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: expected writes are queued per scenario and popped on winc.
// Build with FIFO_WR_ARBITER_PRIO_EN defined to exercise the requester-0 priority variant.
module tb_fifo_wr_arbiter;
  localparam int DSIZE = 8;

  typedef struct packed {
    logic [3:0]       ack;
    logic [DSIZE-1:0] data;
  } wr_t;

`ifdef FIFO_WR_ARBITER_PRIO_EN
  localparam int PRIO_OWNER = 0;
`else
  localparam int PRIO_OWNER = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  wr_t  exp_q[$];
  logic [DSIZE-1:0] lanes [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

  fifo_wr_arbiter_if #(.DSIZE(DSIZE)) bus ();

  fifo_wr_arbiter #(.DSIZE(DSIZE), .BURST(4), .STALL_LIMIT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic drive(input logic [3:0] r, input logic w, input logic rs);
    @(posedge clk);
    #1;
    bus.req   = r;
    bus.wfull = w;
    rst       = rs;
    @(negedge clk);
  endtask

  task automatic push_writes(input int owner, input int n);
    wr_t e;
    e.ack  = 4'(1 << owner);
    e.data = lanes[owner];
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive((k < 2) ? 4'b1111 : 4'b0000, 1'b0, (k < 2) ? 1'b1 : 1'b0);
      checks++;
      if ({bus.gnt, bus.ack, bus.winc, bus.abort, bus.wdata} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_outputs k=%0d: got gnt=%b ack=%b winc=%b abort=%b wdata=%h, want all zero",
                 k, bus.gnt, bus.ack, bus.winc, bus.abort, bus.wdata);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [DSIZE-1:0] ew;
    wr_t e;
    for (int g = 0; g < 5; g++) push_writes(g % 4, 4);
    for (int k = 0; k < 26; k++) begin
      drive((k < 25) ? 4'b1111 : 4'b0000, 1'b0, 1'b0);
      eg = 4'b0000;
      ew = '0;
      if (k > 0 && ((k - 1) % 5) < 4) begin
        eg = 4'(1 << (((k - 1) / 5) % 4));
        ew = lanes[((k - 1) / 5) % 4];
      end
      checks++;
      if (bus.gnt !== eg || bus.abort !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rr_gnt k=%0d: got gnt=%b abort=%b, want gnt=%b abort=0", k, bus.gnt, bus.abort, eg);
      end
      checks++;
      if (bus.wdata !== ew) begin
        errors++;
        $display("[TB] FAIL rr_wdata k=%0d: got %h, want %h", k, bus.wdata, ew);
      end
      checks++;
      if (bus.winc) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rr_extra_write k=%0d: got ack=%b, want no write", k, bus.ack);
        end else begin
          e = exp_q.pop_front();
          if (bus.ack !== e.ack || bus.wdata !== e.data) begin
            errors++;
            $display("[TB] FAIL rr_write k=%0d: got ack=%b data=%h, want ack=%b data=%h",
                     k, bus.ack, bus.wdata, e.ack, e.data);
          end
        end
      end else if (bus.ack !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL rr_ack_idle k=%0d: got %b, want 0000", k, bus.ack);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rr_missing_writes: got %0d left over, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_early_release();
    logic [3:0] rq [9] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1011, 4'b1011, 4'b0000, 4'b0000};
    logic [3:0] eg [9] = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000};
    wr_t e;
    push_writes(2, 2);
    push_writes(3, 1);
    for (int k = 0; k < 9; k++) begin
      drive(rq[k], 1'b0, 1'b0);
      checks++;
      if (bus.gnt !== eg[k] || bus.abort !== 1'b0) begin
        errors++;
        $display("[TB] FAIL early_gnt k=%0d: got gnt=%b abort=%b, want gnt=%b abort=0", k, bus.gnt, bus.abort, eg[k]);
      end
      checks++;
      if (bus.winc) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL early_extra_write k=%0d: got ack=%b, want no write", k, bus.ack);
        end else begin
          e = exp_q.pop_front();
          if (bus.ack !== e.ack || bus.wdata !== e.data) begin
            errors++;
            $display("[TB] FAIL early_write k=%0d: got ack=%b data=%h, want ack=%b data=%h",
                     k, bus.ack, bus.wdata, e.ack, e.data);
          end
        end
      end else if (bus.ack !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL early_ack_idle k=%0d: got %b, want 0000", k, bus.ack);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL early_missing_writes: got %0d left over, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_stall_abort();
    logic [3:0] eg;
    logic       ea;
    logic [DSIZE-1:0] ew;
    for (int k = 0; k < 19; k++) begin
      drive((k <= 16) ? 4'b0010 : 4'b0000, (k <= 16) ? 1'b1 : 1'b0, 1'b0);
      eg = (k >= 1 && k <= 16) ? 4'b0010 : 4'b0000;
      ew = (k >= 1 && k <= 16) ? lanes[1] : '0;
      ea = (k == 17);
      checks++;
      if (bus.gnt !== eg || bus.abort !== ea) begin
        errors++;
        $display("[TB] FAIL stall_gnt_abort k=%0d: got gnt=%b abort=%b, want gnt=%b abort=%b",
                 k, bus.gnt, bus.abort, eg, ea);
      end
      checks++;
      if (bus.winc !== 1'b0 || bus.ack !== 4'b0000 || bus.wdata !== ew) begin
        errors++;
        $display("[TB] FAIL stall_no_write k=%0d: got winc=%b ack=%b wdata=%h, want winc=0 ack=0000 wdata=%h",
                 k, bus.winc, bus.ack, bus.wdata, ew);
      end
    end
  endtask

  task automatic test_stall_resume();
    logic [3:0] eg;
    wr_t e;
    push_writes(0, 4);
    for (int k = 0; k < 9; k++) begin
      drive((k <= 7) ? 4'b0001 : 4'b0000, (k >= 2 && k <= 4), 1'b0);
      eg = (k >= 1 && k <= 7) ? 4'b0001 : 4'b0000;
      checks++;
      if (bus.gnt !== eg || bus.abort !== 1'b0) begin
        errors++;
        $display("[TB] FAIL resume_gnt k=%0d: got gnt=%b abort=%b, want gnt=%b abort=0", k, bus.gnt, bus.abort, eg);
      end
      checks++;
      if (bus.winc) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL resume_extra_write k=%0d: got ack=%b, want no write", k, bus.ack);
        end else begin
          e = exp_q.pop_front();
          if (bus.ack !== e.ack || bus.wdata !== e.data) begin
            errors++;
            $display("[TB] FAIL resume_write k=%0d: got ack=%b data=%h, want ack=%b data=%h",
                     k, bus.ack, bus.wdata, e.ack, e.data);
          end
        end
      end else if (bus.ack !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL resume_ack_idle k=%0d: got %b, want 0000", k, bus.ack);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL resume_missing_writes: got %0d left over, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    logic [3:0] eg [7] = '{4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    wr_t e;
    push_writes(1, 2);
    push_writes(0, 1);
    for (int k = 0; k < 7; k++) begin
      drive((k <= 4) ? 4'b1111 : 4'b0000, 1'b0, (k == 2));
      checks++;
      if (bus.gnt !== eg[k] || bus.abort !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rstmid_gnt k=%0d: got gnt=%b abort=%b, want gnt=%b abort=0", k, bus.gnt, bus.abort, eg[k]);
      end
      checks++;
      if (bus.winc) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rstmid_extra_write k=%0d: got ack=%b, want no write", k, bus.ack);
        end else begin
          e = exp_q.pop_front();
          if (bus.ack !== e.ack || bus.wdata !== e.data) begin
            errors++;
            $display("[TB] FAIL rstmid_write k=%0d: got ack=%b data=%h, want ack=%b data=%h",
                     k, bus.ack, bus.wdata, e.ack, e.data);
          end
        end
      end else if (bus.ack !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL rstmid_ack_idle k=%0d: got %b, want 0000", k, bus.ack);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rstmid_missing_writes: got %0d left over, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_priority();
    logic [3:0] eg;
    wr_t e;
    push_writes(PRIO_OWNER, 1);
    for (int k = 0; k < 4; k++) begin
      drive((k == 0 || k == 1) ? 4'b0011 : 4'b0000, 1'b0, 1'b0);
      eg = (k == 1 || k == 2) ? 4'(1 << PRIO_OWNER) : 4'b0000;
      checks++;
      if (bus.gnt !== eg) begin
        errors++;
        $display("[TB] FAIL prio_gnt k=%0d: got %b, want %b", k, bus.gnt, eg);
      end
      checks++;
      if (bus.winc) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL prio_extra_write k=%0d: got ack=%b, want no write", k, bus.ack);
        end else begin
          e = exp_q.pop_front();
          if (bus.ack !== e.ack || bus.wdata !== e.data) begin
            errors++;
            $display("[TB] FAIL prio_write k=%0d: got ack=%b data=%h, want ack=%b data=%h",
                     k, bus.ack, bus.wdata, e.ack, e.data);
          end
        end
      end else if (bus.ack !== 4'b0000) begin
        errors++;
        $display("[TB] FAIL prio_ack_idle k=%0d: got %b, want 0000", k, bus.ack);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL prio_missing_writes: got %0d left over, want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    rst       = 1'b1;
    bus.req   = 4'b0000;
    bus.wfull = 1'b0;
    bus.din   = {lanes[3], lanes[2], lanes[1], lanes[0]};
    $display("[TB] starting fifo_wr_arbiter bench");
    test_reset();
    test_round_robin();
    test_early_release();
    test_stall_abort();
    test_stall_resume();
    test_reset_mid_burst();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter DSIZE, default 8, meaning width of each write-data lane.
REQ-002 SHALL have parameter BURST, default 4, meaning maximum FIFO writes per grant (range 1..15).
REQ-003 SHALL have parameter STALL_LIMIT, default 16, meaning consecutive wfull cycles before a grant is aborted (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  4  per-requester write request; bit i belongs to requester i.
REQ-007 SHALL have port din  input  4*DSIZE  requester data; lane i is din[i*DSIZE +: DSIZE].
REQ-008 SHALL have port wfull  input  1  FIFO full flag, same clock domain.
REQ-009 SHALL have port gnt  output  4  one-hot registered grant; all-zero when no owner.
REQ-010 SHALL have port ack  output  4  one-hot; bit i high in the cycle requester i's data is written.
REQ-011 SHALL have port winc  output  1  FIFO write enable.
REQ-012 SHALL have port wdata  output  DSIZE  FIFO write data, lane of the current owner; zero when gnt is zero.
REQ-013 SHALL have port abort  output  1  one-cycle pulse when a grant is released by stall timeout.

Function
REQ-014 SHALL implement states IDLE and GRANT; gnt non-zero only in GRANT.
REQ-015 In IDLE with any req bit set, SHALL select the owner round-robin, starting at index (last+1) mod 4, enter GRANT and assert gnt on the next edge (1-cycle grant latency).
REQ-016 In IDLE with req == 0, SHALL remain in IDLE with gnt = 0.
REQ-017 winc SHALL be combinational: winc = (state == GRANT) & req[owner] & ~wfull; ack = gnt when winc is 1, else 0.
REQ-018 wdata SHALL equal din lane of owner whenever gnt is non-zero, independent of winc.
REQ-019 A burst counter SHALL clear on grant entry and increment on each winc; it SHALL never exceed BURST.
REQ-020 GRANT SHALL return to IDLE on the edge after the write that makes the count equal BURST.
REQ-021 GRANT SHALL return to IDLE on the edge after a cycle in which req[owner] is 0, even if the count is below BURST.
REQ-022 A stall counter SHALL increment each GRANT cycle with req[owner] & wfull, clear on any other cycle, and saturate at STALL_LIMIT.
REQ-023 When the stall counter reaches STALL_LIMIT, SHALL return to IDLE on the next edge and pulse abort for exactly that one cycle (abort registered, aligned with gnt going to 0).
REQ-024 On every return to IDLE, SHALL record the owner index as last; at least one IDLE cycle occurs between consecutive grants.
REQ-025 SHALL ignore changes to non-owner req bits during GRANT; gnt stays stable for the whole grant.
REQ-026 When wfull and the release condition of REQ-021 coincide, REQ-021 SHALL take precedence, with no abort pulse.

Reset
REQ-027 While rst is high at a rising edge, SHALL set state = IDLE, gnt = 0, abort = 0, burst and stall counters = 0, and last = 3, so requester 0 wins the first arbitration.
REQ-028 Reset asserted mid-burst SHALL force winc = 0 and ack = 0 from the following cycle, with no further write of the aborted burst.

Configuration
REQ-029 Macro FIFO_WR_ARBITER_PRIO_EN: when defined, SHALL make requester 0 win any IDLE arbitration in which req[0] = 1, regardless of last; other requesters stay round-robin among themselves.
REQ-030 Without FIFO_WR_ARBITER_PRIO_EN, SHALL use pure round-robin for all four requesters per REQ-015.

Verification
REQ-031 Bench SHALL cover: reset, then req = 4'b1111 held, wfull = 0 -> grants in order 0,1,2,3,0, each with exactly 4 winc/ack pulses, and one idle cycle between grants.
REQ-032 Bench SHALL cover: req = 4'b0100 for 2 cycles of GRANT, then 0 -> exactly 2 writes with wdata = din lane 2, gnt = 0 on the next edge, and last = 2.
REQ-033 Bench SHALL cover: owner 1 granted and wfull = 1 for 16 cycles -> winc = 0 throughout, abort pulses once, and gnt = 0 in the same cycle as abort.
REQ-034 Bench SHALL cover: wfull = 1 for 3 cycles mid-burst, then 0 -> the burst resumes, 4 writes total, no abort, and the counter holds during the stall.
REQ-035 Bench SHALL cover: rst = 1 in the 2nd write cycle of a burst -> gnt, winc, ack and abort = 0 from the next cycle, and the next grant goes to requester 0.
REQ-036 Bench SHALL cover: with FIFO_WR_ARBITER_PRIO_EN defined, last = 0 and req = 4'b0011 -> requester 0 is granted again; without the macro, requester 1 is granted.
